acq_controller: RTL and testbench
=================================

Name: acq_controller

Overview:
Acquisition sequencer for the DiscReader core. It drives DiscReader RUN according to a programmable start condition (immediate or Nth index pulse) and stop condition (index count, byte limit, RAM full or host abort). It counts bytes DiscReader writes to the acquisition FIFO/RAM and reports state and stop reason to the host register file. It sits between the host register block and the DiscReader, FD_INDEX_IN and RAM-full flag.

Parameters:
BCNT_WIDTH, 19, width of BYTE_COUNT and BYTE_LIMIT (sized for acquisition RAM depth)
FLUSH_CLKS, 8, clocks spent in FLUSH after RUN drops so DiscReader can finish a pending store
TIMEOUT_WIDTH, 32, width of the start-wait timeout counter (used only with ACQ_TIMEOUT_EN)

Ports:
CLOCK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
START  in  1  one-clock start strobe from host
ABORT  in  1  one-clock abort strobe from host
START_MODE  in  1  0 = immediate, 1 = wait for START_COUNT index edges
START_COUNT  in  8  index edges to wait (0 treated as 1)
STOP_MODE  in  2  0 = manual, 1 = after STOP_COUNT index edges, 2 = after BYTE_LIMIT bytes, 3 = reserved (treated as 0)
STOP_COUNT  in  8  index edges to acquire (0 treated as 1)
BYTE_LIMIT  in  BCNT_WIDTH  byte count that ends acquisition in STOP_MODE 2
FD_INDEX_IN  in  1  raw index pulse from drive, asynchronous
RD_WRITE  in  1  DiscReader WRITE strobe, one clock per stored byte
RAM_FULL  in  1  acquisition RAM full flag
RUN  out  1  to DiscReader RUN
STATE  out  3  0 IDLE, 1 WAIT_START, 2 ACQUIRE, 3 FLUSH, 4 DONE
STOP_REASON  out  2  0 none/manual, 1 index count, 2 byte limit, 3 RAM full/timeout
BYTE_COUNT  out  BCNT_WIDTH  bytes stored since last START
INDEX_SEEN  out  8  index edges counted during ACQUIRE

Behaviour:
- Reset: state IDLE, RUN=0, STOP_REASON=0, BYTE_COUNT=0, INDEX_SEEN=0, all internal counters 0. RESET mid-acquisition drops RUN asynchronously.
- Index: FD_INDEX_IN passes through a 2-FF synchroniser plus a previous-value register. A rising edge yields a one-clock idx_edge 3 clocks after the input rises. A long pulse gives exactly one edge.
- START is accepted only in IDLE or DONE and ignored elsewhere. On accept: BYTE_COUNT, INDEX_SEEN and STOP_REASON are cleared. Control inputs are latched. Next state is ACQUIRE if START_MODE=0, else WAIT_START.
- WAIT_START: decrement the latched start count on each idx_edge. When the last edge is seen, go to ACQUIRE; that edge is not counted in INDEX_SEEN.
- RUN is registered: it is 1 exactly while STATE==ACQUIRE. It rises the clock after the START or final-idx_edge cycle.
- ACQUIRE: INDEX_SEEN increments on each idx_edge (saturates at 255). Stop checks run in this priority: ABORT (reason 0) > RAM_FULL (reason 3) > STOP_MODE 2 with BYTE_COUNT+RD_WRITE >= BYTE_LIMIT (reason 2) > STOP_MODE 1 with INDEX_SEEN reaching STOP_COUNT (reason 1). Any stop moves to FLUSH next clock, and RUN=0 from that clock.
- FLUSH: lasts FLUSH_CLKS clocks, then DONE. ABORT in FLUSH goes straight to DONE.
- ABORT in WAIT_START: go to DONE, reason 0, RUN never asserted.
- BYTE_COUNT increments on RD_WRITE in ACQUIRE and FLUSH, saturating at all-ones. RD_WRITE in IDLE, WAIT_START or DONE is ignored.
- DONE holds all outputs until the next START. A simultaneous ABORT and START in DONE: START is ignored.
- STOP_MODE 0/3: acquisition ends only on ABORT or RAM_FULL.

Optional Feature:
Macro ACQ_TIMEOUT_EN.
- Defined: adds input TIMEOUT_CLKS [TIMEOUT_WIDTH-1:0]. A counter runs in WAIT_START. If it reaches TIMEOUT_CLKS (nonzero) before the start condition is met, go to DONE with STOP_REASON=3 and RUN never asserted. TIMEOUT_CLKS=0 disables the timeout.
- Not defined: the port and counter are absent, and WAIT_START waits indefinitely.

Test Plan:
- Reset, then START with START_MODE=0, STOP_MODE=0; wait 100 clks; ABORT -> RUN high from clock after START to clock after ABORT; STATE 2→3, then DONE after 8 clks; STOP_REASON=0.
- START_MODE=1, START_COUNT=2; index pulses 50 clks wide (first at +20 clks, second at +1000 clks) -> RUN rises 4 clks after second pulse rises; INDEX_SEEN=0.
- STOP_MODE=1, STOP_COUNT=3; 3 index pulses in ACQUIRE -> RUN falls 4 clks after third pulse rises; INDEX_SEEN=3; STOP_REASON=1.
- STOP_MODE=2, BYTE_LIMIT=10; pulse RD_WRITE 12 times (2 during FLUSH) -> RUN falls the clock after the 10th strobe; BYTE_COUNT=12; STOP_REASON=2.
- RAM_FULL and ABORT asserted on the same ACQUIRE clock -> STOP_REASON=0. RAM_FULL alone -> STOP_REASON=3.
- ACQ_TIMEOUT_EN defined, TIMEOUT_CLKS=500, START_MODE=1, no index -> DONE after 500 clks; STOP_REASON=3; RUN stays 0 throughout.

Source files
------------

// File: rtl/acq_if.sv
// Host/DiscReader-side signal bundle for the acquisition sequencer.
// master: host register block / drive side (drives control and status inputs).
// slave : acq_controller (consumes control, drives RUN and status).
// Optional macro ACQ_TIMEOUT_EN adds TIMEOUT_CLKS (width TIMEOUT_WIDTH).
interface acq_if #(
  parameter int unsigned BCNT_WIDTH    = 19
`ifdef ACQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_WIDTH = 32
`endif
);
  logic                  START;
  logic                  ABORT;
  logic                  START_MODE;
  logic [7:0]            START_COUNT;
  logic [1:0]            STOP_MODE;
  logic [7:0]            STOP_COUNT;
  logic [BCNT_WIDTH-1:0] BYTE_LIMIT;
  logic                  FD_INDEX_IN;
  logic                  RD_WRITE;
  logic                  RAM_FULL;
`ifdef ACQ_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CLKS;
`endif
  logic                  RUN;
  logic [2:0]            STATE;
  logic [1:0]            STOP_REASON;
  logic [BCNT_WIDTH-1:0] BYTE_COUNT;
  logic [7:0]            INDEX_SEEN;

  modport master (
`ifdef ACQ_TIMEOUT_EN
    output TIMEOUT_CLKS,
`endif
    output START, ABORT, START_MODE, START_COUNT, STOP_MODE, STOP_COUNT,
    output BYTE_LIMIT, FD_INDEX_IN, RD_WRITE, RAM_FULL,
    input  RUN, STATE, STOP_REASON, BYTE_COUNT, INDEX_SEEN
  );

  modport slave (
`ifdef ACQ_TIMEOUT_EN
    input  TIMEOUT_CLKS,
`endif
    input  START, ABORT, START_MODE, START_COUNT, STOP_MODE, STOP_COUNT,
    input  BYTE_LIMIT, FD_INDEX_IN, RD_WRITE, RAM_FULL,
    output RUN, STATE, STOP_REASON, BYTE_COUNT, INDEX_SEEN
  );
endinterface

// File: rtl/acq_controller.sv
// Acquisition sequencer for the DiscReader core: starts RUN immediately or
// after N index edges, stops on abort / RAM full / byte limit / index count,
// counts stored bytes and reports state and stop reason.
// Ports: CLOCK, RESET (async, active high), bus (acq_if.slave):
//   inputs  START ABORT START_MODE START_COUNT STOP_MODE STOP_COUNT
//           BYTE_LIMIT FD_INDEX_IN RD_WRITE RAM_FULL [TIMEOUT_CLKS]
//   outputs RUN STATE STOP_REASON BYTE_COUNT INDEX_SEEN (all registered)
// Optional macro ACQ_TIMEOUT_EN: start-wait timeout via TIMEOUT_CLKS.
module acq_controller #(
  parameter int unsigned BCNT_WIDTH    = 19,
  parameter int unsigned FLUSH_CLKS    = 8
`ifdef ACQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_WIDTH = 32
`endif
) (
  input  logic CLOCK,
  input  logic RESET,
  acq_if.slave bus
);

  localparam int unsigned FLUSH_W = (FLUSH_CLKS > 1) ? $clog2(FLUSH_CLKS) : 1;
  localparam int unsigned SUM_W   = BCNT_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_ACQUIRE    = 3'd2,
    S_FLUSH      = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  run_q;
  logic [1:0]            reason_q, reason_d;
  logic [BCNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [7:0]            iseen_q, iseen_d;
  logic [7:0]            start_rem_q, start_rem_d;
  logic [7:0]            stop_cnt_q, stop_cnt_d;
  logic [1:0]            stop_mode_q, stop_mode_d;
  logic [BCNT_WIDTH-1:0] byte_lim_q, byte_lim_d;
  logic [FLUSH_W-1:0]    flush_q, flush_d;
`ifdef ACQ_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_lim_q, tmo_lim_d;
`endif

  // Index edge detect: 2-FF synchroniser, previous value, registered edge
  logic sync1_q, sync2_q, prev_q, idx_edge_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      idx_edge_q <= 1'b0;
    end else begin
      sync1_q    <= bus.FD_INDEX_IN;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      idx_edge_q <= sync2_q & ~prev_q;
    end
  end

  logic             bcnt_inc;
  logic [SUM_W-1:0] bcnt_sum;
  logic             start_ok;

  // Next-state and counter logic
  always_comb begin
    state_d     = state_q;
    reason_d    = reason_q;
    bcnt_d      = bcnt_q;
    iseen_d     = iseen_q;
    start_rem_d = start_rem_q;
    stop_cnt_d  = stop_cnt_q;
    stop_mode_d = stop_mode_q;
    byte_lim_d  = byte_lim_q;
    flush_d     = flush_q;
`ifdef ACQ_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_lim_d   = tmo_lim_q;
`endif
    bcnt_inc = bus.RD_WRITE && (bcnt_q != {BCNT_WIDTH{1'b1}});
    bcnt_sum = {1'b0, bcnt_q} + SUM_W'(bus.RD_WRITE);
    // A START coinciding with ABORT in DONE is dropped
    start_ok = bus.START && !(state_q == S_DONE && bus.ABORT);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          bcnt_d      = '0;
          iseen_d     = '0;
          reason_d    = 2'd0;
          start_rem_d = (bus.START_COUNT == 8'd0) ? 8'd1 : bus.START_COUNT;
          stop_cnt_d  = (bus.STOP_COUNT == 8'd0) ? 8'd1 : bus.STOP_COUNT;
          stop_mode_d = bus.STOP_MODE;
          byte_lim_d  = bus.BYTE_LIMIT;
`ifdef ACQ_TIMEOUT_EN
          tmo_cnt_d   = '0;
          tmo_lim_d   = bus.TIMEOUT_CLKS;
`endif
          state_d     = bus.START_MODE ? S_WAIT_START : S_ACQUIRE;
        end
      end

      S_WAIT_START: begin
`ifdef ACQ_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + TIMEOUT_WIDTH'(1);
`endif
        if (bus.ABORT) begin
          reason_d = 2'd0;
          state_d  = S_DONE;
        end else if (idx_edge_q && start_rem_q <= 8'd1) begin
          state_d = S_ACQUIRE;
        end else if (idx_edge_q) begin
          start_rem_d = start_rem_q - 8'd1;
        end
`ifdef ACQ_TIMEOUT_EN
        // Start condition wins over a timeout expiring on the same clock
        else if (tmo_lim_q != '0 && (tmo_cnt_q + TIMEOUT_WIDTH'(1)) == tmo_lim_q) begin
          reason_d = 2'd3;
          state_d  = S_DONE;
        end
`endif
      end

      S_ACQUIRE: begin
        if (bcnt_inc) bcnt_d = bcnt_q + BCNT_WIDTH'(1);
        if (idx_edge_q && iseen_q != 8'hFF) iseen_d = iseen_q + 8'd1;
        flush_d = FLUSH_W'(FLUSH_CLKS - 1);
        // Stop priority: abort > RAM full > byte limit > index count
        if (bus.ABORT) begin
          reason_d = 2'd0;
          state_d  = S_FLUSH;
        end else if (bus.RAM_FULL) begin
          reason_d = 2'd3;
          state_d  = S_FLUSH;
        end else if (stop_mode_q == 2'd2 && bcnt_sum >= {1'b0, byte_lim_q}) begin
          reason_d = 2'd2;
          state_d  = S_FLUSH;
        end else if (stop_mode_q == 2'd1 && iseen_d >= stop_cnt_q) begin
          reason_d = 2'd1;
          state_d  = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (bcnt_inc) bcnt_d = bcnt_q + BCNT_WIDTH'(1);
        if (bus.ABORT || flush_q == '0) begin
          state_d = S_DONE;
        end else begin
          flush_d = flush_q - FLUSH_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      reason_q    <= 2'd0;
      bcnt_q      <= '0;
      iseen_q     <= '0;
      start_rem_q <= '0;
      stop_cnt_q  <= '0;
      stop_mode_q <= '0;
      byte_lim_q  <= '0;
      flush_q     <= '0;
`ifdef ACQ_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_lim_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      run_q       <= (state_d == S_ACQUIRE);
      reason_q    <= reason_d;
      bcnt_q      <= bcnt_d;
      iseen_q     <= iseen_d;
      start_rem_q <= start_rem_d;
      stop_cnt_q  <= stop_cnt_d;
      stop_mode_q <= stop_mode_d;
      byte_lim_q  <= byte_lim_d;
      flush_q     <= flush_d;
`ifdef ACQ_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_lim_q   <= tmo_lim_d;
`endif
    end
  end

  assign bus.RUN         = run_q;
  assign bus.STATE       = 3'(state_q);
  assign bus.STOP_REASON = reason_q;
  assign bus.BYTE_COUNT  = bcnt_q;
  assign bus.INDEX_SEEN  = iseen_q;

endmodule

// File: tb/tb_acq_controller.sv
// Directed bench for acq_controller: start modes, all stop causes, flush
// timing, DONE behaviour, async reset and (with ACQ_TIMEOUT_EN) timeout.
module tb_acq_controller;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 CLOCK = ~CLOCK;

  acq_if #(.BCNT_WIDTH(19)) bus ();

  acq_controller #(.BCNT_WIDTH(19), .FLUSH_CLKS(8)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks, leaving time 1 unit after the last rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.START = 1'b1; tick(1); bus.START = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.ABORT = 1'b1; tick(1); bus.ABORT = 1'b0;
  endtask

  initial begin
    bit run_seen;
    bus.START = 0; bus.ABORT = 0; bus.START_MODE = 0; bus.START_COUNT = 0;
    bus.STOP_MODE = 0; bus.STOP_COUNT = 0; bus.BYTE_LIMIT = '0;
    bus.FD_INDEX_IN = 0; bus.RD_WRITE = 0; bus.RAM_FULL = 0;
`ifdef ACQ_TIMEOUT_EN
    bus.TIMEOUT_CLKS = '0;
`endif
    tick(3);
    RESET = 1'b0;
    tick(1);
    chk("rst_state", 32'(bus.STATE), 0);
    chk("rst_run", 32'(bus.RUN), 0);
    chk("rst_reason", 32'(bus.STOP_REASON), 0);
    chk("rst_bcnt", 32'(bus.BYTE_COUNT), 0);
    chk("rst_iseen", 32'(bus.INDEX_SEEN), 0);

    // Immediate start, manual stop via ABORT
    pulse_start();
    chk("t1_run_up", 32'(bus.RUN), 1);
    chk("t1_state_acq", 32'(bus.STATE), 2);
    tick(99);
    chk("t1_run_hold", 32'(bus.RUN), 1);
    pulse_abort();
    chk("t1_run_down", 32'(bus.RUN), 0);
    chk("t1_state_flush", 32'(bus.STATE), 3);
    tick(7);
    chk("t1_flush_last", 32'(bus.STATE), 3);
    tick(1);
    chk("t1_done", 32'(bus.STATE), 4);
    chk("t1_reason", 32'(bus.STOP_REASON), 0);

    // Start on 2nd index edge, stop after 3 index edges
    bus.START_MODE = 1; bus.START_COUNT = 2; bus.STOP_MODE = 1; bus.STOP_COUNT = 3;
    pulse_start();
    chk("t2_wait", 32'(bus.STATE), 1);
    chk("t2_run0", 32'(bus.RUN), 0);
    tick(20);
    bus.FD_INDEX_IN = 1; tick(50); bus.FD_INDEX_IN = 0;
    chk("t2_still_wait", 32'(bus.STATE), 1);
    tick(930);
    bus.FD_INDEX_IN = 1;
    tick(3);
    chk("t2_run_not_yet", 32'(bus.RUN), 0);
    tick(1);
    chk("t2_run_up", 32'(bus.RUN), 1);
    chk("t2_state_acq", 32'(bus.STATE), 2);
    tick(46); bus.FD_INDEX_IN = 0;
    tick(10);
    chk("t2_iseen0", 32'(bus.INDEX_SEEN), 0);
    for (int p = 1; p <= 3; p++) begin
      bus.FD_INDEX_IN = 1;
      tick(3);
      chk("t3_run_pre", 32'(bus.RUN), 1);
      tick(1);
      chk("t3_iseen", 32'(bus.INDEX_SEEN), 32'(p));
      chk("t3_run_post", 32'(bus.RUN), (p == 3) ? 32'd0 : 32'd1);
      tick(6); bus.FD_INDEX_IN = 0; tick(10);
    end
    chk("t3_done", 32'(bus.STATE), 4);
    chk("t3_reason", 32'(bus.STOP_REASON), 1);
    chk("t3_iseen_hold", 32'(bus.INDEX_SEEN), 3);

    // Byte limit stop, strobes during FLUSH still counted
    bus.START_MODE = 0; bus.STOP_MODE = 2; bus.BYTE_LIMIT = 19'd10;
    pulse_start();
    chk("t4_iseen_clr", 32'(bus.INDEX_SEEN), 0);
    chk("t4_reason_clr", 32'(bus.STOP_REASON), 0);
    for (int i = 1; i <= 10; i++) begin
      bus.RD_WRITE = 1; tick(1); bus.RD_WRITE = 0;
      chk("t4_run", 32'(bus.RUN), (i == 10) ? 32'd0 : 32'd1);
      tick(1);
    end
    chk("t4_bcnt10", 32'(bus.BYTE_COUNT), 10);
    bus.RD_WRITE = 1; tick(1); bus.RD_WRITE = 0; tick(1);
    bus.RD_WRITE = 1; tick(1); bus.RD_WRITE = 0;
    chk("t4_in_flush", 32'(bus.STATE), 3);
    tick(8);
    chk("t4_done", 32'(bus.STATE), 4);
    chk("t4_bcnt12", 32'(bus.BYTE_COUNT), 12);
    chk("t4_reason", 32'(bus.STOP_REASON), 2);
    bus.RD_WRITE = 1; tick(1); bus.RD_WRITE = 0;
    chk("t4_done_nowrite", 32'(bus.BYTE_COUNT), 12);
    bus.START = 1; bus.ABORT = 1; tick(1); bus.START = 0; bus.ABORT = 0;
    chk("t4_start_abort_state", 32'(bus.STATE), 4);
    chk("t4_start_abort_bcnt", 32'(bus.BYTE_COUNT), 12);

    // RAM full alone, then RAM full with ABORT
    bus.STOP_MODE = 0;
    pulse_start();
    chk("t5_bcnt_clr", 32'(bus.BYTE_COUNT), 0);
    tick(5);
    bus.RAM_FULL = 1; tick(1); bus.RAM_FULL = 0;
    chk("t5_full_state", 32'(bus.STATE), 3);
    chk("t5_full_reason", 32'(bus.STOP_REASON), 3);
    pulse_abort();
    chk("t5_flush_abort", 32'(bus.STATE), 4);
    pulse_start();
    chk("t5_reason_clr", 32'(bus.STOP_REASON), 0);
    tick(5);
    bus.RAM_FULL = 1; bus.ABORT = 1; tick(1); bus.RAM_FULL = 0; bus.ABORT = 0;
    chk("t5_both_state", 32'(bus.STATE), 3);
    chk("t5_both_reason", 32'(bus.STOP_REASON), 0);
    tick(8);
    chk("t5_both_done", 32'(bus.STATE), 4);

    // ABORT while waiting for index
    bus.START_MODE = 1; bus.START_COUNT = 0;
    pulse_start();
    tick(5);
    pulse_abort();
    chk("t6_wait_abort_state", 32'(bus.STATE), 4);
    chk("t6_wait_abort_run", 32'(bus.RUN), 0);
    chk("t6_wait_abort_reason", 32'(bus.STOP_REASON), 0);

`ifdef ACQ_TIMEOUT_EN
    // Start-wait timeout without any index pulse
    bus.TIMEOUT_CLKS = 32'd500;
    pulse_start();
    run_seen = 1'b0;
    for (int c = 1; c < 500; c++) begin
      tick(1);
      if (bus.RUN) run_seen = 1'b1;
    end
    chk("t7_pre_timeout", 32'(bus.STATE), 1);
    tick(1);
    chk("t7_timeout_state", 32'(bus.STATE), 4);
    chk("t7_timeout_reason", 32'(bus.STOP_REASON), 3);
    chk("t7_run_never", 32'(run_seen), 0);
    bus.TIMEOUT_CLKS = '0;
`else
    run_seen = 1'b0;
`endif

    // Async reset mid-acquisition drops RUN without a clock edge
    bus.START_MODE = 0;
    pulse_start();
    tick(3);
    chk("t8_run_before", 32'(bus.RUN), 1);
    #2 RESET = 1'b1;
    #1;
    chk("t8_async_run", 32'(bus.RUN), 0);
    chk("t8_async_state", 32'(bus.STATE), 0);
    tick(2);
    RESET = 1'b0;
    tick(2);
    chk("t8_idle_after", 32'(bus.STATE), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
